// File: rtl/fas_serial_ctrl_if.sv
// Operation bus for the bit-serial add/subtract sequencer: operand/mode request
// plus busy/done status and the captured result.
interface fas_serial_ctrl_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         a_ns;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout_out;

  modport master (
    output start, a_in, b_in, a_ns,
    input  busy, done, result, cout_out
  );

  modport slave (
    input  start, a_in, b_in, a_ns,
    output busy, done, result, cout_out
  );
endinterface

// File: rtl/fas_serial_ctrl.sv
// Bit-serial add/subtract sequencer around the combinational fas cell: feeds one
// operand bit pair per clock LSB first, recirculates carry/borrow, shifts in sums.
module fas_serial_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst,
  fas_serial_ctrl_if.slave  op,
  output logic              fa_a,
  output logic              fa_b,
  output logic              fa_cin,
  output logic              fa_a_ns,
  input  logic              fa_s,
  input  logic              fa_cout
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [N-1:0]     a_sh;
  logic [N-1:0]     b_sh;
  logic             carry;
  logic             mode;
  logic [CNT_W-1:0] cnt;
  logic [N-2:0]     res_sh;
  logic [N-1:0]     sum_next;

  // Only N-1 sum bits are ever parked; the last one goes straight to the output.
  assign sum_next = {fa_s, res_sh};

  // Shift registers drain to zero and carry/mode are cleared on the final bit,
  // so the fas feed is all-zero outside RUN without any start-to-output path.
  assign fa_a    = a_sh[0];
  assign fa_b    = b_sh[0];
  assign fa_cin  = carry;
  assign fa_a_ns = mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      mode        <= 1'b0;
      cnt         <= '0;
      res_sh      <= '0;
      op.busy     <= 1'b0;
      op.done     <= 1'b0;
      op.result   <= '0;
      op.cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          op.done <= 1'b0;
          if (op.start) begin
            a_sh    <= op.a_in;
            b_sh    <= op.b_in;
            mode    <= op.a_ns;
            carry   <= 1'b0;
            cnt     <= '0;
            op.busy <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          carry  <= fa_cout;
          res_sh <= sum_next[N-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            cnt         <= '0;
            carry       <= 1'b0;
            mode        <= 1'b0;
            op.result   <= sum_next;
            op.cout_out <= fa_cout;
            op.busy     <= 1'b0;
            op.done     <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          op.done <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fas_serial_ctrl.sv
// Directed bench for fas_serial_ctrl with a delayed behavioural fas cell in the loop.
module tb_fas_serial_ctrl;

  localparam int unsigned N = 4;

  logic clk;
  logic rst;
  logic fa_a, fa_b, fa_cin, fa_a_ns;
  logic fa_s, fa_cout;

  int checks = 0;
  int errors = 0;

  fas_serial_ctrl_if #(.N(N)) op_if ();

  fas_serial_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op_if.slave),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_a_ns (fa_a_ns),
    .fa_s    (fa_s),
    .fa_cout (fa_cout)
  );

  // fas cell: a_ns=1 full add, a_ns=0 full subtract a-b-cin with borrow out.
  assign #4 fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign #4 fa_cout = fa_a_ns ? ((fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin))
                              : ((~fa_a & fa_b) | (~fa_a & fa_cin) | (fa_b & fa_cin));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                        input logic [N-1:0] er, input logic ec, input string tag);
    int unsigned busy_cycles;
    @(negedge clk);
    op_if.start = 1'b1;
    op_if.a_in  = a;
    op_if.b_in  = b;
    op_if.a_ns  = m;
    @(negedge clk);
    op_if.start = 1'b0;
    op_if.a_in  = '0;
    op_if.b_in  = '0;
    op_if.a_ns  = ~m;
    check({tag, "_fa_a"}, fa_a, a[0]);
    check({tag, "_fa_b"}, fa_b, b[0]);
    check({tag, "_fa_a_ns"}, fa_a_ns, m);
    check({tag, "_fa_cin"}, fa_cin, 0);
    busy_cycles = 0;
    for (int unsigned i = 0; i < N; i++) begin
      check({tag, "_done_early"}, op_if.done, 0);
      if (op_if.busy) busy_cycles++;
      @(negedge clk);
    end
    check({tag, "_done"}, op_if.done, 1);
    check({tag, "_busy_in_done"}, op_if.busy, 0);
    check({tag, "_result"}, op_if.result, er);
    check({tag, "_cout"}, op_if.cout_out, ec);
    check({tag, "_busy_cycles"}, busy_cycles, N);
    @(negedge clk);
    check({tag, "_done_pulse"}, op_if.done, 0);
    check({tag, "_result_held"}, op_if.result, er);
    check({tag, "_idle_fa_a_ns"}, fa_a_ns, 0);
  endtask

  initial begin
    int unsigned done_cnt;

    rst         = 1'b1;
    op_if.start = 1'b0;
    op_if.a_in  = '0;
    op_if.b_in  = '0;
    op_if.a_ns  = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", op_if.busy, 0);
    check("rst_done", op_if.done, 0);
    check("rst_result", op_if.result, 0);
    check("rst_cout", op_if.cout_out, 0);
    check("rst_fa", {fa_a, fa_b, fa_cin, fa_a_ns}, 0);
    rst = 1'b1;

    run_op(4'd5,  4'd3, 1'b1, 4'd8,  1'b0, "add_5_3");
    run_op(4'd15, 4'd1, 1'b1, 4'd0,  1'b1, "add_15_1");
    run_op(4'd9,  4'd9, 1'b1, 4'd2,  1'b1, "add_9_9");
    run_op(4'd7,  4'd2, 1'b0, 4'd5,  1'b0, "sub_7_2");
    run_op(4'd2,  4'd7, 1'b0, 4'd11, 1'b1, "sub_2_7");
    run_op(4'd6,  4'd6, 1'b0, 4'd0,  1'b0, "sub_6_6");

    // Start during RUN and operand/mode changes after accept must be ignored.
    @(negedge clk);
    op_if.start = 1'b1;
    op_if.a_in  = 4'd3;
    op_if.b_in  = 4'd4;
    op_if.a_ns  = 1'b1;
    @(negedge clk);
    op_if.a_in  = 4'd1;
    op_if.b_in  = 4'd1;
    op_if.a_ns  = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    op_if.start = 1'b0;
    op_if.a_in  = 4'd15;
    op_if.a_ns  = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (op_if.done) begin
        done_cnt++;
        check("ign_result", op_if.result, 7);
        check("ign_cout", op_if.cout_out, 0);
      end
      @(negedge clk);
    end
    check("ign_done_count", done_cnt, 1);
    check("ign_idle_busy", op_if.busy, 0);

    // start held high: one op every N+2 cycles.
    op_if.start = 1'b1;
    op_if.a_in  = 4'd1;
    op_if.b_in  = 4'd2;
    op_if.a_ns  = 1'b1;
    for (int unsigned idx = 0; idx < 18; idx++) begin
      @(negedge clk);
      check("b2b_done", op_if.done, (idx % 6 == 4) ? 1 : 0);
      if (idx % 6 == 4) check("b2b_result", op_if.result, 3);
    end
    op_if.start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset after two bits of 6+7.
    op_if.start = 1'b1;
    op_if.a_in  = 4'd6;
    op_if.b_in  = 4'd7;
    op_if.a_ns  = 1'b1;
    @(negedge clk);
    op_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", op_if.busy, 1);
    rst = 1'b0;
    #1;
    check("arst_busy", op_if.busy, 0);
    check("arst_done", op_if.done, 0);
    check("arst_result", op_if.result, 0);
    check("arst_cout", op_if.cout_out, 0);
    check("arst_fa", {fa_a, fa_b, fa_cin, fa_a_ns}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst_no_done", op_if.done, 0);
    end

    run_op(4'd10, 4'd5, 1'b1, 4'd15, 1'b0, "add_10_5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
